// File: rtl/controlador_recepcao_ram_if.sv
// Signal bundle between the UART receiver, the receive controller and the RAM write port.
interface controlador_recepcao_ram_if;
   logic       rx_done;
   logic [7:0] rx_data;
   logic [8:0] a_ram;
   logic [7:0] d_ram;
   logic       wren_ram;
   logic       clock_ram;

   modport master (
      input  rx_done,
      input  rx_data,
      output a_ram,
      output d_ram,
      output wren_ram,
      output clock_ram
   );

   modport slave (
      output rx_done,
      output rx_data,
      input  a_ram,
      input  d_ram,
      input  wren_ram,
      input  clock_ram
   );
endinterface

// File: rtl/controlador_recepcao_ram.sv
// Receive-side RAM loader: stores UART bytes at consecutive RAM words, flags frame
// completion, discards stale partial frames after an idle timeout and reports dropped bytes.
module controlador_recepcao_ram #(
   parameter int N_PALAVRAS     = 134,
   parameter int TIMEOUT_CICLOS = 50000000
) (
   input  logic                       clock,
   input  logic                       reset,
   controlador_recepcao_ram_if.master bus,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       timeout_erro,
   output logic                       overrun,
   output logic [8:0]                 contagem
);
   localparam int            TW     = $clog2(TIMEOUT_CICLOS) + 1;
   localparam logic [8:0]    ULTIMO = 9'(N_PALAVRAS - 1);
   localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 1);
   localparam logic [TW-1:0] ZERO_T = TW'(0);
   localparam logic [TW-1:0] UM_T   = TW'(1);

   typedef enum logic [2:0] {
      ESPERA     = 3'd0,
      END_CFG    = 3'd1,
      ESCREVE    = 3'd2,
      INCREMENTA = 3'd3,
      FIM        = 3'd4
   } estado_t;

   estado_t       estado_r;
   logic [8:0]    i_r;
   logic [7:0]    dado_r;
   logic [TW-1:0] timer_r;
   logic          wren_r;
   logic          clock_ram_r;
   logic          busy_r;
   logic          frame_done_r;
   logic          timeout_erro_r;
   logic          overrun_r;

   // {wren_ram, clock_ram, busy} as seen while sitting in state s
   function automatic logic [2:0] saidas(input estado_t s);
      case (s)
         ESPERA:          saidas = 3'b000;
         END_CFG:         saidas = 3'b101;
         ESCREVE:         saidas = 3'b111;
         INCREMENTA, FIM: saidas = 3'b001;
         default:         saidas = 3'b000;
      endcase
   endfunction

   // Frame-loading FSM; Moore outputs are registered together with the state they decode
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_r       <= ESPERA;
         i_r            <= 9'd0;
         dado_r         <= 8'd0;
         timer_r        <= ZERO_T;
         wren_r         <= 1'b0;
         clock_ram_r    <= 1'b0;
         busy_r         <= 1'b0;
         frame_done_r   <= 1'b0;
         timeout_erro_r <= 1'b0;
         overrun_r      <= 1'b0;
      end else begin
         frame_done_r   <= 1'b0;
         timeout_erro_r <= 1'b0;
         overrun_r      <= bus.rx_done && (estado_r != ESPERA);
         case (estado_r)
            ESPERA: begin
               // an arriving byte takes priority over a timeout expiring on the same edge
               if (bus.rx_done) begin
                  dado_r   <= bus.rx_data;
                  timer_r  <= ZERO_T;
                  estado_r <= END_CFG;
                  {wren_r, clock_ram_r, busy_r} <= saidas(END_CFG);
               end else if (i_r != 9'd0) begin
                  if (timer_r == LIMITE) begin
                     i_r            <= 9'd0;
                     timer_r        <= ZERO_T;
                     timeout_erro_r <= 1'b1;
                  end else begin
                     timer_r <= timer_r + UM_T;
                  end
               end else begin
                  timer_r <= ZERO_T;
               end
            end
            END_CFG: begin
               estado_r <= ESCREVE;
               {wren_r, clock_ram_r, busy_r} <= saidas(ESCREVE);
            end
            ESCREVE: begin
               estado_r <= INCREMENTA;
               {wren_r, clock_ram_r, busy_r} <= saidas(INCREMENTA);
            end
            INCREMENTA: begin
               if (i_r == ULTIMO) begin
                  i_r          <= 9'd0;
                  estado_r     <= FIM;
                  frame_done_r <= 1'b1;
                  {wren_r, clock_ram_r, busy_r} <= saidas(FIM);
               end else begin
                  i_r      <= i_r + 9'd1;
                  estado_r <= ESPERA;
                  {wren_r, clock_ram_r, busy_r} <= saidas(ESPERA);
               end
            end
            FIM: begin
               estado_r <= ESPERA;
               {wren_r, clock_ram_r, busy_r} <= saidas(ESPERA);
            end
            default: begin
               estado_r <= ESPERA;
               {wren_r, clock_ram_r, busy_r} <= saidas(ESPERA);
            end
         endcase
      end
   end

   assign bus.a_ram     = i_r;
   assign bus.d_ram     = dado_r;
   assign bus.wren_ram  = wren_r;
   assign bus.clock_ram = clock_ram_r;
   assign busy          = busy_r;
   assign frame_done    = frame_done_r;
   assign timeout_erro  = timeout_erro_r;
   assign overrun       = overrun_r;
   assign contagem      = i_r;
endmodule

// File: tb/tb_controlador_recepcao_ram.sv
// Self-checking bench for controlador_recepcao_ram with a small frame and short timeout.
module tb_controlador_recepcao_ram;
   localparam int N  = 4;
   localparam int TO = 100;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       busy;
   logic       frame_done;
   logic       timeout_erro;
   logic       overrun;
   logic [8:0] contagem;

   controlador_recepcao_ram_if bus ();

   controlador_recepcao_ram #(.N_PALAVRAS(N), .TIMEOUT_CICLOS(TO)) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus),
      .busy         (busy),
      .frame_done   (frame_done),
      .timeout_erro (timeout_erro),
      .overrun      (overrun),
      .contagem     (contagem)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_frames = 0, n_timeouts = 0, n_overruns = 0;
   int last_frame_cyc = -1, last_to_cyc = -1, last_ov_cyc = -1;
   int exp_idx = 0, exp_frames = 0, exp_timeouts = 0, exp_overruns = 0;
   logic [7:0] ram [0:511];

   always @(posedge clock) cyc <= cyc + 1;

   // behavioural RAM: captures data on the rising edge of the strobe
   always @(posedge bus.clock_ram) begin
      if (bus.wren_ram) ram[bus.a_ram] <= bus.d_ram;
   end

   always @(negedge clock) begin
      if (frame_done) begin
         n_frames <= n_frames + 1;
         last_frame_cyc <= cyc;
      end
      if (timeout_erro) begin
         n_timeouts <= n_timeouts + 1;
         last_to_cyc <= cyc;
      end
      if (overrun) begin
         n_overruns <= n_overruns + 1;
         last_ov_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // one-cycle rx_done pulse; t is the index of the edge that samples it
   task automatic send(input logic [7:0] d, output int t);
      bus.rx_done = 1'b1;
      bus.rx_data = d;
      @(negedge clock);
      bus.rx_done = 1'b0;
      t = cyc;
   endtask

   // reference: an accepted byte fills the next word; the last word closes the frame
   task automatic accept();
      if (exp_idx == N - 1) begin
         exp_idx = 0;
         exp_frames++;
      end else begin
         exp_idx++;
      end
   endtask

   task automatic put_byte(input logic [7:0] d, input int gap, output int t);
      int  addr;
      bit  last;
      addr = exp_idx;
      last = (exp_idx == N - 1);
      send(d, t);
      accept();
      tick(gap);
      check("ram_word", ram[addr], d);
      check("contagem", contagem, exp_idx);
      check("busy_idle", busy, 1'b0);
      check("frames", n_frames, exp_frames);
      if (last) check("frame_latency", last_frame_cyc, t + 3);
   endtask

   initial begin
      int t, t2;
      logic [7:0] b, b2;
      bus.rx_done = 1'b0;
      bus.rx_data = 8'd0;
      reset = 1'b0;
      tick(3);
      check("rst_a_ram", bus.a_ram, 9'd0);
      check("rst_d_ram", bus.d_ram, 8'd0);
      check("rst_wren", bus.wren_ram, 1'b0);
      check("rst_clock_ram", bus.clock_ram, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_timeout", timeout_erro, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_contagem", contagem, 9'd0);
      reset = 1'b1;

      // idle with an empty frame never times out
      tick(150);
      check("idle_no_timeout", n_timeouts, exp_timeouts);

      put_byte(8'hA1, 20, t);
      put_byte(8'hB2, 20, t);
      put_byte(8'hC3, 20, t);
      put_byte(8'hD4, 20, t);

      // partial frame abandoned after TO idle clocks in ESPERA
      put_byte(8'h55, 5, t);
      tick(145);
      exp_idx = 0;
      exp_timeouts++;
      check("timeout_count", n_timeouts, exp_timeouts);
      check("timeout_cycle", last_to_cyc, t + 3 + TO);
      check("timeout_contagem", contagem, exp_idx);
      put_byte(8'h66, 5, t);

      // second byte two clocks later lands while busy and is dropped
      b = 8'($urandom);
      send(b, t);
      accept();
      tick(1);
      send(~b, t2);
      tick(6);
      exp_overruns++;
      check("overrun_count", n_overruns, exp_overruns);
      check("overrun_cycle", last_ov_cyc, t + 2);
      check("overrun_ram", ram[1], b);
      check("overrun_dado", bus.d_ram, b);
      check("overrun_contagem", contagem, exp_idx);

      // byte arriving on the very edge the timeout would expire
      b = 8'($urandom);
      send(b, t);
      accept();
      tick(TO + 2);
      b2 = 8'($urandom);
      send(b2, t2);
      accept();
      tick(6);
      check("race_no_timeout", n_timeouts, exp_timeouts);
      check("race_ram2", ram[2], b);
      check("race_ram3", ram[3], b2);
      check("race_frames", n_frames, exp_frames);
      check("race_frame_latency", last_frame_cyc, t2 + 3);
      check("race_contagem", contagem, exp_idx);

      // reset pulled while word 2 is being written
      put_byte(8'($urandom), 5, t);
      put_byte(8'($urandom), 5, t);
      send(8'($urandom), t);
      tick(1);
      check("escreve_wren", bus.wren_ram, 1'b1);
      check("escreve_clock_ram", bus.clock_ram, 1'b1);
      check("escreve_busy", busy, 1'b1);
      reset = 1'b0;
      tick(1);
      exp_idx = 0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_contagem", contagem, exp_idx);
      check("midrst_wren", bus.wren_ram, 1'b0);
      check("midrst_clock_ram", bus.clock_ram, 1'b0);
      reset = 1'b1;
      tick(10);
      check("midrst_frames", n_frames, exp_frames);

      for (int k = 0; k < 10; k++) begin
         put_byte(8'($urandom), int'($urandom_range(30, 5)), t);
      end
      check("total_frames", n_frames, exp_frames);
      check("total_timeouts", n_timeouts, exp_timeouts);
      check("total_overruns", n_overruns, exp_overruns);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
